lsu_mem_stage: RTL and testbench

//  Memory-stage load/store unit fed by the MW control pipeline register (rd_en, wr_en, func3) plus ALU address/store data.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_mem_stage_if.sv | 14 +
 rtl/lsu_load_align.sv | 31 +++
 rtl/lsu_mem_stage.sv | 169 ++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage LSU: width codes, FSM states and
// byte-enable / store-lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: be_of = 4'b0001 << off;
      F3_H, F3_HU: be_of = 4'b0011 << off;
      default:     be_of = 4'b1111;
    endcase
  endfunction

  // Store data replicated into every lane so the byte enables alone pick the target.
  function automatic logic [31:0] lane_of(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      F3_B, F3_BU: lane_of = {4{w[7:0]}};
      F3_H, F3_HU: lane_of = {2{w[15:0]}};
      default:     lane_of = w;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave).
interface lsu_mem_stage_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a loaded word and sign/zero extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (func3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one bus access per load/store, stalls
// the pipe while it is outstanding, formats load data and flags bad accesses.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  lsu_mem_stage_if.master   mem,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              fault_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              flushed_q, flushed_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              mis_q, mis_d;
  logic              fault_q, fault_d;

  logic        access, illegal, misal, go, bad;
  logic [31:0] load_data;

  always_comb begin
    case (func3_i)
      F3_B, F3_H, F3_W: illegal = rd_en_i & wr_en_i;
      F3_BU, F3_HU:     illegal = wr_en_i;
      default:          illegal = 1'b1;
    endcase
  end

  assign access  = rd_en_i | wr_en_i;
  assign misal   = (((func3_i == F3_H) || (func3_i == F3_HU)) && addr_i[0])
                 | ((func3_i == F3_W) && (addr_i[1:0] != 2'b00));
  assign go      = (state_q == IDLE) & access & ~illegal & ~misal & ~flush_i;
  assign bad     = (state_q == IDLE) & access & (illegal | misal) & ~flush_i;
  assign stall_o = go | (state_q == REQ) | (state_q == WAIT);
  assign cnt_inc = cnt_q + CNT_W'(1);

  lsu_load_align u_align (
    .word_i  (mem.rdata),
    .off_i   (off_q),
    .func3_i (f3_q),
    .data_o  (load_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    flushed_d = flushed_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    mis_d     = 1'b0;
    fault_d   = 1'b0;
    case (state_q)
      IDLE: begin
        mis_d = bad;
        if (go) begin
          state_d   = REQ;
          cnt_d     = '0;
          addr_d    = {addr_i[ADDR_W-1:2], 2'b00};
          be_d      = be_of(func3_i, addr_i[1:0]);
          wdata_d   = lane_of(func3_i, wdata_i);
          we_d      = wr_en_i;
          f3_d      = func3_i;
          off_d     = addr_i[1:0];
          flushed_d = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        // A grant in the same cycle as a flush wins: the access is already on the bus.
        if (flush_i && !mem.gnt) begin
          state_d = IDLE;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else if (mem.gnt) begin
          state_d   = WAIT;
          flushed_d = flush_i;
        end
      end
      WAIT: begin
        cnt_d     = cnt_inc;
        flushed_d = flushed_q | flush_i;
        if (mem.rvalid) begin
          state_d = DONE;
          if (!we_q && !flushed_d) begin
            rdata_d  = load_data;
            rvalid_d = 1'b1;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      flushed_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      mis_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      flushed_q <= flushed_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      mis_q     <= mis_d;
      fault_q   <= fault_d;
    end
  end

  assign mem.req       = (state_q == REQ);
  assign mem.we        = we_q;
  assign mem.addr      = addr_q;
  assign mem.be        = be_q;
  assign mem.wdata     = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign misalign_o    = mis_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: each access is planned as a timeline (grant, response,
// flush cycles) and the expected outputs per cycle are derived from that plan.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rd_en, wr_en, flush;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_o;
  logic        rdata_valid_o, stall_o, misalign_o, fault_o;

  lsu_mem_stage_if #(.ADDR_W(32)) mem ();

  lsu_mem_stage #(.ADDR_W(32), .TIMEOUT(T)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_en_i       (rd_en),
    .wr_en_i       (wr_en),
    .func3_i       (func3),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .flush_i       (flush),
    .mem           (mem),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .stall_o       (stall_o),
    .misalign_o    (misalign_o),
    .fault_o       (fault_o)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int n_mis = 0, n_fault = 0, n_req = 0;
  bit chk_en = 1'b0;
  bit exp_stall, exp_req, exp_rv, exp_mis, exp_fault, exp_we;
  logic [31:0] exp_rdata = 32'd0, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] obs_addr = 32'd0, obs_wdata = 32'd0;
  logic [3:0]  obs_be = 4'd0;
  bit          obs_we = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference rules ----
  function automatic int m_size(input logic [2:0] f3);
    return (f3 == F3_B || f3 == F3_BU) ? 1 : (f3 == F3_H || f3 == F3_HU) ? 2 : 4;
  endfunction

  function automatic bit m_bad(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit ill;
    ill = (rd && wr) || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (wr && f3[2]);
    return ill || ((a % m_size(f3)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n = m_size(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_lanes(input logic [2:0] f3, input logic [31:0] w);
    int n = m_size(f3);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [31:0] word, input logic [1:0] off, input logic [2:0] f3);
    int n = m_size(f3);
    logic [31:0] s, mask;
    if (n == 4) return word;
    s    = word >> (8 * off);
    mask = (32'h1 << (8 * n)) - 32'h1;
    s    = s & mask;
    if ((f3 == F3_B || f3 == F3_H) && s[8*n-1]) s = s | ~mask;
    return s;
  endfunction

  // ---- compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall_o), 32'(exp_stall));
      check("mem_req", 32'(mem.req), 32'(exp_req));
      check("rdata_valid", 32'(rdata_valid_o), 32'(exp_rv));
      check("misalign", 32'(misalign_o), 32'(exp_mis));
      check("fault", 32'(fault_o), 32'(exp_fault));
      check("rdata", rdata_o, exp_rdata);
      if (exp_req) begin
        check("mem_addr", mem.addr, exp_addr);
        check("mem_be", 32'(mem.be), 32'(exp_be));
        check("mem_wdata", mem.wdata, exp_wdata);
        check("mem_we", 32'(mem.we), 32'(exp_we));
      end
      if (mem.req) begin
        n_req++;
        obs_addr = mem.addr; obs_be = mem.be; obs_wdata = mem.wdata; obs_we = mem.we;
      end
      if (misalign_o) n_mis++;
      if (fault_o) n_fault++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
    func3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = $urandom;
  endtask

  task automatic exp_idle();
    exp_stall = 0; exp_req = 0; exp_rv = 0; exp_mis = 0; exp_fault = 0;
  endtask

  // One instruction: grant gd cycles after the request appears, response rdl
  // cycles after the grant; fmode 1 flush in REQ, 2 flush in WAIT, 3 flush on arrival.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                            input int gd, input int rdl, input int fmode, input int fsel);
    int g, v, f, last, busy_end, req_end, gl;
    bit abort, complete, late;
    exp_addr = {a[31:2], 2'b00}; exp_be = m_be(f3, a);
    exp_wdata = m_lanes(f3, wd); exp_we = wr;
    if (m_bad(rd, wr, f3, a)) begin
      rd_en = rd; wr_en = wr; func3 = f3; addr = a; wdata = wd; flush = 1'b0;
      exp_idle(); step();
      drive_idle(); exp_idle(); exp_mis = 1; step();
      return;
    end
    g = 1 + gd; v = g + 1 + rdl; f = -1;
    gl = (g < T) ? g : T;
    abort = (fmode == 3) || (fmode == 1 && gl >= 2);
    if (fmode == 3) f = 0;
    else if (abort) f = 1 + fsel % (gl - 1);
    complete = !abort && g < T && v <= T;
    if (complete && fmode == 2) f = g + 1 + fsel % (v - g);
    late     = !abort && !complete && g < T;
    last     = abort ? f : complete ? v + 1 : T;
    busy_end = abort ? f : complete ? v : T;
    req_end  = abort ? f : gl;
    for (int c = 0; c <= last + 1; c++) begin
      if (c <= last) begin
        rd_en = rd; wr_en = wr; func3 = f3; addr = a; wdata = wd;
      end else begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
      flush      = (c == f);
      mem.gnt    = !abort && g < T && c == g;
      mem.rvalid = (complete && c == v) || (late && c == last + 1);
      mem.rdata  = mem.rvalid ? word : $urandom;
      exp_stall  = (c == 0 && f != 0) || (c >= 1 && c <= busy_end);
      exp_req    = c >= 1 && c <= req_end;
      exp_rv     = complete && rd && c == v + 1 && !(f > g && f <= v);
      if (exp_rv) exp_rdata = m_fmt(word, a[1:0], f3);
      exp_mis    = 0;
      exp_fault  = !abort && !complete && c == T + 1;
      step();
    end
    drive_idle();
    exp_idle();
  endtask

  initial begin
    int pm, pf, pr;
    drive_idle();
    exp_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(mem.req), 32'd0);
    check("rst_addr", mem.addr, 32'd0);
    check("rst_be", 32'(mem.be), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_pulses", {29'd0, rdata_valid_o, misalign_o, fault_o}, 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step();

    // directed cases with hand-computed results
    run_access(1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
    check("lw_rdata", rdata_o, 32'hDEADBEEF);
    check("lw_addr", obs_addr, 32'h100);
    check("lw_be", 32'(obs_be), 32'hF);
    run_access(1, 0, F3_B, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);
    check("lb_rdata", rdata_o, 32'hFFFFFF80);
    check("lb_be", 32'(obs_be), 32'h8);
    run_access(1, 0, F3_BU, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);
    check("lbu_rdata", rdata_o, 32'h00000080);
    run_access(0, 1, F3_H, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, 0, 0);
    check("sh_be", 32'(obs_be), 32'hC);
    check("sh_wdata", obs_wdata, 32'hABCDABCD);
    check("sh_we", 32'(obs_we), 32'd1);
    check("sh_rdata_held", rdata_o, 32'h00000080);
    pm = n_mis; pr = n_req;
    run_access(1, 0, F3_W, 32'h101, 32'h0, 32'h0, 0, 0, 0, 0);
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0);
    check("bad_mis_count", 32'(n_mis - pm), 32'd2);
    check("bad_no_req", 32'(n_req - pr), 32'd0);
    pr = n_req;
    run_access(1, 0, F3_W, 32'h400, 32'h0, 32'h11223344, 3, 1, 0, 0);
    check("slow_gnt_req_cycles", 32'(n_req - pr), 32'd4);
    check("slow_gnt_rdata", rdata_o, 32'h11223344);
    run_access(1, 0, F3_W, 32'h500, 32'h0, 32'h55555555, 3, 0, 1, 1);
    check("flush_req_rdata_kept", rdata_o, 32'h11223344);
    pf = n_fault;
    run_access(1, 0, F3_W, 32'h600, 32'h0, 32'h0, 0, 20, 0, 0);
    check("timeout_fault_count", 32'(n_fault - pf), 32'd1);

    // asynchronous reset while waiting for the response
    chk_en = 1'b0;
    rd_en = 1'b1; func3 = F3_W; addr = 32'h700;
    step();
    mem.gnt = 1'b1;
    step();
    mem.gnt = 1'b0;
    #2 reset_n = 1'b0;
    drive_idle();
    #1;
    check("arst_stall", 32'(stall_o), 32'd0);
    check("arst_req", 32'(mem.req), 32'd0);
    check("arst_rdata", rdata_o, 32'd0);
    check("arst_addr", mem.addr, 32'd0);
    check("arst_pulses", {29'd0, rdata_valid_o, misalign_o, fault_o}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_rdata = 32'd0;
    exp_idle();
    chk_en = 1'b1;
    step();

    // randomized accesses
    for (int i = 0; i < 250; i++) begin
      int gaps, r, gd, rdl, fm, fmode;
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      gaps = $urandom_range(0, 2);
      for (int k = 0; k < gaps; k++) begin
        drive_idle(); exp_idle(); step();
      end
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      f3 = ($urandom_range(0, 7) < 6) ? ((r < 5) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 2)))
                                      : 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~32'(m_size(f3) - 1);
      gd  = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
      rdl = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 3);
      fm  = $urandom_range(0, 9);
      fmode = (fm == 7) ? 1 : (fm == 8) ? 2 : (fm == 9) ? 3 : 0;
      run_access(rd, wr, f3, a, $urandom, $urandom, gd, rdl, fmode, $urandom_range(0, 15));
    end

    drive_idle(); exp_idle(); step(); step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
